crc5_stream_engine: RTL and testbench
=====================================

// Module: crc5_stream_engine
// PURPOSE
//  Downstream consumer of the synchronous FIFO. Pops one WIDTH-bit word per valid/ready
//  handshake and computes CRC5 (poly x^5+x^2+1, 5'h05) over it, MSB first. Presents
//  {word, crc} downstream on a registered valid/ready interface. Counts completed words.
// PARAMETERS
//  WIDTH    8      data word width in bits (>=2)
//  INIT     5'h1F  CRC register seed, loaded per word
//  CNT_W    16     width of WORD_CNT
// PORTS
//  CLK         in   1          single clock, all state on rising edge
//  RESET       in   1          asynchronous, active-high reset
//  DATA_UP     in   WIDTH      word from FIFO DATA_DOWN
//  VALID_UP    in   1          FIFO VALID_DOWN
//  READY_UP    out  1          to FIFO READY_DOWN
//  DATA_DOWN   out  WIDTH+5    {word, crc[4:0]}, registered
//  VALID_DOWN  out  1          result valid, registered
//  READY_DOWN  in   1          downstream accept
//  BUSY        out  1          high in any state other than IDLE
//  WORD_CNT    out  CNT_W      count of downstream handshakes, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset (async, RESET=1): state=IDLE; DATA_DOWN=0; VALID_DOWN=0; WORD_CNT=0; BUSY=0;
//    crc/shift/bit counter=0. Mid-operation reset discards partial word; no output results.
//  - READY_UP is combinational from state only: 1 in IDLE, 0 otherwise (serial mode).
//  - Handshakes: transfer when VALID & READY at a rising edge. VALID_DOWN/DATA_DOWN hold
//    stable until accepted; never deassert without a handshake.
//  - CRC step per bit b: fb=crc[4]^b; crc={crc[3:0],1'b0}^(fb?5'h05:5'h00). No final XOR.
//  - FSM (serial):
//    IDLE : on VALID_UP&READY_UP -> latch word, crc<=INIT, bit_idx<=WIDTH-1 -> SHIFT.
//    SHIFT: process word[bit_idx] each cycle; at bit_idx==0 load DATA_DOWN={word,crc_next},
//           VALID_DOWN<=1 -> DONE. Else bit_idx<=bit_idx-1.
//    DONE : hold; on READY_DOWN -> VALID_DOWN<=0, WORD_CNT+=1 -> IDLE.
//  - Latency: accepted at edge k -> VALID_DOWN high after edge k+WIDTH. Throughput: at most
//    one word per WIDTH+2 cycles when READY_DOWN=1.
//  - READY_DOWN held low: block stalls in DONE indefinitely; READY_UP stays 0; FIFO fills.
//  - VALID_UP low in IDLE: no state change. READY_DOWN in IDLE/SHIFT is ignored.
//  - WORD_CNT at all-ones + handshake -> 0.
// CONFIGURATION
//  CRC5_PARALLEL_EN defined:
//   - SHIFT state not built; CRC over the full word is computed combinationally (unrolled
//     WIDTH steps of the same recurrence, identical result) in the accept cycle.
//   - Accept at edge k -> DATA_DOWN/VALID_DOWN registered at edge k, state DONE.
//   - READY_UP = (state==IDLE) | (state==DONE & READY_DOWN): simultaneous pop/push in DONE
//     reloads the output register, stays in DONE; WORD_CNT still increments. One word/cycle.
//  CRC5_PARALLEL_EN undefined: bit-serial FSM above; no unrolled logic.
// TESTING
//  1 Reset: assert RESET async mid-cycle during SHIFT -> VALID_DOWN=0, READY_UP=1, WORD_CNT=0,
//    BUSY=0 immediately; no result emitted after release.
//  2 Known vector: WIDTH=8, INIT=5'h1F, push 8'h00 -> DATA_DOWN=13'h000F (crc 5'h0F);
//    serial: VALID_DOWN high after 8 edges past accept; parallel: after 1 edge.
//  3 Vectors INIT=5'h00: 8'h01 -> crc 5'h05; 8'h80 -> crc 5'h0E; 8'h00 -> crc 5'h00.
//  4 Back-pressure: READY_DOWN=0 for 20 cycles with FIFO holding 2 words -> DATA_DOWN stable,
//    READY_UP=0 (serial), FIFO full; release -> both words out in order, WORD_CNT=2.
//  5 Streaming (CRC5_PARALLEL_EN, READY_DOWN=1, VALID_UP=1): 100 random words -> 100 results
//    in order, one per cycle after first, CRC matches MATLAB DPI model; WORD_CNT=100.
//  6 Wrap: CNT_W=4, 17 words -> WORD_CNT=1.

Source files
------------

// File: rtl/crc5_stream_engine.sv
// crc5_stream_engine: pops WIDTH-bit words from an upstream FIFO, computes a
// CRC5 (x^5+x^2+1, MSB first, seed INIT, no final XOR) over each word, and
// presents {word, crc} downstream on a registered valid/ready port.
// WORD_CNT counts downstream handshakes and wraps modulo 2^CNT_W.
//
// Build option: CRC5_PARALLEL_EN
//   undefined (default): bit-serial FSM IDLE -> SHIFT (WIDTH cycles) -> DONE.
//   defined: CRC is unrolled combinationally over the incoming word, the
//            result registers in the accept cycle and DONE can pop/push in
//            the same cycle (one word per clock).
//
// Valid/ready: a transfer happens on a rising CLK edge where VALID and READY
// are both high. Once VALID_DOWN is raised, it and DATA_DOWN stay unchanged
// until that transfer happens; VALID_DOWN never drops without one.
module crc5_stream_engine #(
  parameter int         WIDTH = 8,
  parameter logic [4:0] INIT  = 5'h1F,
  parameter int         CNT_W = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [WIDTH-1:0]   DATA_UP,
  input  logic               VALID_UP,
  output logic               READY_UP,
  output logic [WIDTH+4:0]   DATA_DOWN,
  output logic               VALID_DOWN,
  input  logic               READY_DOWN,
  output logic               BUSY,
  output logic [CNT_W-1:0]   WORD_CNT,
  output logic [1:0]         DBG_STATE
);

  localparam logic [4:0] POLY = 5'h05;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One MSB-first CRC5 step for a single input bit.
  function automatic logic [4:0] crc_step(input logic [4:0] c, input logic b);
    logic fb;
    fb = c[4] ^ b;
    return {c[3:0], 1'b0} ^ (fb ? POLY : 5'h00);
  endfunction

  state_t             r_state;
  logic [WIDTH+4:0]   r_data_down;
  logic               r_valid_down;
  logic [CNT_W-1:0]   r_word_cnt;

`ifndef CRC5_PARALLEL_EN
  localparam int IDX_W = $clog2(WIDTH);

  logic [WIDTH-1:0]   r_word;
  logic [4:0]         r_crc;
  logic [IDX_W-1:0]   r_bit_idx;
  logic [4:0]         w_crc_next;

  // CRC after folding in the current bit of the latched word.
  assign w_crc_next = crc_step(r_crc, r_word[r_bit_idx]);

  // Serial mode accepts only when nothing is in flight.
  assign READY_UP = (r_state == IDLE);
`else
  logic [4:0] w_crc_word;

  // Whole-word CRC of the incoming word, same recurrence unrolled.
  always_comb begin
    w_crc_word = INIT;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      w_crc_word = crc_step(w_crc_word, DATA_UP[i]);
    end
  end

  // DONE may take a new word in the same cycle its result leaves.
  assign READY_UP = (r_state == IDLE) || ((r_state == DONE) && READY_DOWN);
`endif

  assign DATA_DOWN  = r_data_down;
  assign VALID_DOWN = r_valid_down;
  assign WORD_CNT   = r_word_cnt;
  assign BUSY       = (r_state != IDLE);
  assign DBG_STATE  = r_state;

  // Control FSM with registered downstream outputs and handshake counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= IDLE;
      r_data_down  <= '0;
      r_valid_down <= 1'b0;
      r_word_cnt   <= '0;
`ifndef CRC5_PARALLEL_EN
      r_word       <= '0;
      r_crc        <= '0;
      r_bit_idx    <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (VALID_UP && READY_UP) begin
`ifndef CRC5_PARALLEL_EN
            r_word    <= DATA_UP;
            r_crc     <= INIT;
            r_bit_idx <= IDX_W'(WIDTH - 1);
            r_state   <= SHIFT;
`else
            r_data_down  <= {DATA_UP, w_crc_word};
            r_valid_down <= 1'b1;
            r_state      <= DONE;
`endif
          end
        end
`ifndef CRC5_PARALLEL_EN
        SHIFT: begin
          r_crc <= w_crc_next;
          if (r_bit_idx == '0) begin
            r_data_down  <= {r_word, w_crc_next};
            r_valid_down <= 1'b1;
            r_state      <= DONE;
          end else begin
            r_bit_idx <= r_bit_idx - IDX_W'(1);
          end
        end
`endif
        DONE: begin
          if (READY_DOWN) begin
            r_word_cnt <= r_word_cnt + CNT_W'(1);
`ifdef CRC5_PARALLEL_EN
            if (VALID_UP) begin
              r_data_down <= {DATA_UP, w_crc_word};
            end else begin
              r_valid_down <= 1'b0;
              r_state      <= IDLE;
            end
`else
            r_valid_down <= 1'b0;
            r_state      <= IDLE;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc5_stream_engine.sv
// Directed bench for crc5_stream_engine. Main instance uses INIT=5'h1F and a
// 16-bit counter; a second instance uses INIT=5'h00 and a 4-bit counter for
// the zero-seed vectors and the counter wrap.
module tb_crc5_stream_engine;

  localparam int WIDTH = 8;
  localparam int DW    = WIDTH + 5;
`ifdef CRC5_PARALLEL_EN
  localparam int LAT_EXP = 0;          // result registers on the accept edge
  localparam int GAP_EXP = 1;
`else
  localparam int LAT_EXP = WIDTH;      // edges after the accept edge
  localparam int GAP_EXP = WIDTH + 2;
`endif

  logic             CLK;
  logic             RESET;
  logic [WIDTH-1:0] DATA_UP;
  logic             VALID_UP;
  logic             READY_UP;
  logic [DW-1:0]    DATA_DOWN;
  logic             VALID_DOWN;
  logic             READY_DOWN;
  logic             BUSY;
  logic [15:0]      WORD_CNT;
  logic [1:0]       DBG_STATE;

  logic [WIDTH-1:0] d2_data_up;
  logic             d2_valid_up;
  logic             d2_ready_up;
  logic [DW-1:0]    d2_data_down;
  logic             d2_valid_down;
  logic             d2_ready_down;
  logic             d2_busy;
  logic [3:0]       d2_word_cnt;
  logic [1:0]       d2_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0]    exp_q[$];
  logic [WIDTH-1:0] src_q[$];
  int               hs_cyc[$];

  crc5_stream_engine dut (
    .CLK(CLK), .RESET(RESET),
    .DATA_UP(DATA_UP), .VALID_UP(VALID_UP), .READY_UP(READY_UP),
    .DATA_DOWN(DATA_DOWN), .VALID_DOWN(VALID_DOWN), .READY_DOWN(READY_DOWN),
    .BUSY(BUSY), .WORD_CNT(WORD_CNT), .DBG_STATE(DBG_STATE)
  );

  crc5_stream_engine #(.WIDTH(8), .INIT(5'h00), .CNT_W(4)) dut2 (
    .CLK(CLK), .RESET(RESET),
    .DATA_UP(d2_data_up), .VALID_UP(d2_valid_up), .READY_UP(d2_ready_up),
    .DATA_DOWN(d2_data_down), .VALID_DOWN(d2_valid_down), .READY_DOWN(d2_ready_down),
    .BUSY(d2_busy), .WORD_CNT(d2_word_cnt), .DBG_STATE(d2_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    RESET = 1'b1;
    VALID_UP = 1'b0; READY_DOWN = 1'b0; DATA_UP = '0;
    d2_valid_up = 1'b0; d2_ready_down = 1'b0; d2_data_up = '0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    @(posedge CLK); #1;
  endtask

  // ---------------- driver tasks ----------------
  // Present one word on the upstream port until it is taken; returns 1 ns
  // after the accept edge.
  task automatic send_word(input logic [WIDTH-1:0] d);
    logic hs;
    logic ok;
    ok = 1'b0;
    DATA_UP = d; VALID_UP = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK); hs = READY_UP;
      @(posedge CLK); #1;
      if (hs) begin ok = 1'b1; break; end
    end
    VALID_UP = 1'b0;
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL send_accept: word %h not accepted, expected accept", d); end
  endtask

  // Edges after the accept edge until VALID_DOWN is seen (bounded).
  task automatic wait_valid(output int edges);
    edges = 0;
    while (!VALID_DOWN && edges < 60) begin
      @(posedge CLK); #1;
      edges++;
    end
  endtask

  task automatic accept_out();
    READY_DOWN = 1'b1;
    @(posedge CLK); #1;
    READY_DOWN = 1'b0;
  endtask

  // Full single-word transaction on the main instance, checked against exp_q.
  task automatic run_word(input logic [WIDTH-1:0] d, input logic [4:0] crc);
    int e;
    logic [DW-1:0] exp;
    exp_q.push_back({d, crc});
    send_word(d);
    wait_valid(e);
    exp = exp_q.pop_front();
    n_checks++;
    if (VALID_DOWN !== 1'b1) begin n_fail++; $display("FAIL word_timeout: VALID_DOWN %b, expected 1 for word %h", VALID_DOWN, d); end
    else if (DATA_DOWN !== exp) begin n_fail++; $display("FAIL word_data: got %h expected %h", DATA_DOWN, exp); end
    accept_out();
  endtask

  // Full single-word transaction on the zero-seed instance.
  task automatic run_word2(input logic [WIDTH-1:0] d, input logic [4:0] crc);
    logic hs;
    int e;
    d2_data_up = d; d2_valid_up = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK); hs = d2_ready_up;
      @(posedge CLK); #1;
      if (hs) break;
    end
    d2_valid_up = 1'b0;
    e = 0;
    while (!d2_valid_down && e < 60) begin @(posedge CLK); #1; e++; end
    n_checks++;
    if (d2_data_down !== {d, crc} || d2_valid_down !== 1'b1) begin
      n_fail++; $display("FAIL word2_data: got %h valid %b expected %h", d2_data_down, d2_valid_down, {d, crc});
    end
    d2_ready_down = 1'b1;
    @(posedge CLK); #1;
    d2_ready_down = 1'b0;
  endtask

  // Cycle-driven stream: src_q acts as the upstream FIFO, exp_q is the
  // scoreboard. READY_DOWN is held low for the first 'hold' cycles.
  task automatic run_stream(input int hold, input int max_cycles);
    int cyc;
    logic up_hs, dn_hs;
    logic [DW-1:0] exp;
    cyc = 0;
    hs_cyc.delete();
    while ((src_q.size() > 0 || exp_q.size() > 0) && cyc < max_cycles) begin
      DATA_UP    = (src_q.size() > 0) ? src_q[0] : '0;
      VALID_UP   = (src_q.size() > 0);
      READY_DOWN = (cyc >= hold);
      @(negedge CLK);
      up_hs = VALID_UP && READY_UP;
      dn_hs = VALID_DOWN && READY_DOWN;
      if (VALID_DOWN && !READY_DOWN && exp_q.size() > 0) begin
        n_checks++;
        if (DATA_DOWN !== exp_q[0]) begin n_fail++; $display("FAIL stall_data: got %h expected %h", DATA_DOWN, exp_q[0]); end
        n_checks++;
        if (READY_UP !== 1'b0) begin n_fail++; $display("FAIL stall_ready_up: got %b expected 0", READY_UP); end
        n_checks++;
        if (src_q.size() != exp_q.size() - 1) begin n_fail++; $display("FAIL stall_fifo: fifo holds %0d expected %0d", src_q.size(), exp_q.size() - 1); end
      end
      if (dn_hs) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL stream_extra: unexpected output %h, expected none", DATA_DOWN);
        end else begin
          exp = exp_q.pop_front();
          if (DATA_DOWN !== exp) begin n_fail++; $display("FAIL stream_data: got %h expected %h", DATA_DOWN, exp); end
        end
        hs_cyc.push_back(cyc);
      end
      @(posedge CLK); #1;
      if (up_hs) void'(src_q.pop_front());
      cyc++;
    end
    VALID_UP = 1'b0; READY_DOWN = 1'b0;
    n_checks++;
    if (exp_q.size() != 0 || src_q.size() != 0) begin
      n_fail++; $display("FAIL stream_timeout: %0d results and %0d words left, expected 0", exp_q.size(), src_q.size());
    end
    exp_q.delete(); src_q.delete();
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    RESET = 1'b1;
    VALID_UP = 1'b0; READY_DOWN = 1'b0; DATA_UP = '0;
    d2_valid_up = 1'b0; d2_ready_down = 1'b0; d2_data_up = '0;
    @(posedge CLK); @(negedge CLK);
    n_checks++; if (VALID_DOWN !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", VALID_DOWN); end
    n_checks++; if (DATA_DOWN !== '0) begin n_fail++; $display("FAIL rst_data: got %h expected 0", DATA_DOWN); end
    n_checks++; if (WORD_CNT !== 16'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d expected 0", WORD_CNT); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", BUSY); end
    n_checks++; if (READY_UP !== 1'b1) begin n_fail++; $display("FAIL rst_ready_up: got %b expected 1", READY_UP); end
    n_checks++; if (DBG_STATE !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d expected 0", DBG_STATE); end
    @(posedge CLK); #1 RESET = 1'b0;
    @(posedge CLK); #1;
  endtask

  // Seed 5'h1F, word 8'h00 gives crc 5'h0F.
  task automatic test_known_vector();
    int e;
    send_word(8'h00);
    wait_valid(e);
    n_checks++; if (e != LAT_EXP) begin n_fail++; $display("FAIL kv_latency: got %0d edges expected %0d", e, LAT_EXP); end
    n_checks++; if (VALID_DOWN !== 1'b1) begin n_fail++; $display("FAIL kv_valid: got %b expected 1", VALID_DOWN); end
    n_checks++; if (DATA_DOWN !== 13'h000F) begin n_fail++; $display("FAIL kv_data: got %h expected 000f", DATA_DOWN); end
    n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL kv_busy: got %b expected 1", BUSY); end
    n_checks++; if (READY_UP !== 1'b0) begin n_fail++; $display("FAIL kv_ready_up: got %b expected 0", READY_UP); end
    n_checks++; if (DBG_STATE !== 2'd2) begin n_fail++; $display("FAIL kv_state: got %0d expected 2", DBG_STATE); end
    accept_out();
    n_checks++; if (VALID_DOWN !== 1'b0) begin n_fail++; $display("FAIL kv_valid_drop: got %b expected 0", VALID_DOWN); end
    n_checks++; if (WORD_CNT !== 16'd1) begin n_fail++; $display("FAIL kv_cnt: got %0d expected 1", WORD_CNT); end
    // VALID_UP low in IDLE: nothing moves
    repeat (3) @(posedge CLK); #1;
    n_checks++; if (DBG_STATE !== 2'd0 || BUSY !== 1'b0) begin n_fail++; $display("FAIL kv_idle_hold: state %0d busy %b expected 0 0", DBG_STATE, BUSY); end
  endtask

  // Hand-derived CRCs for seed 5'h1F.
  task automatic test_vectors();
    run_word(8'h01, 5'h0A);
    run_word(8'h80, 5'h01);
    run_word(8'hA5, 5'h01);
    run_word(8'h3C, 5'h1D);
    run_word(8'hFF, 5'h1B);
    n_checks++; if (WORD_CNT !== 16'd6) begin n_fail++; $display("FAIL vec_cnt: got %0d expected 6", WORD_CNT); end
  endtask

  task automatic test_vectors_init0();
    run_word2(8'h01, 5'h05);
    run_word2(8'h80, 5'h0E);
    run_word2(8'h00, 5'h00);
    n_checks++; if (d2_word_cnt !== 4'd3) begin n_fail++; $display("FAIL vec0_cnt: got %0d expected 3", d2_word_cnt); end
  endtask

  // Async reset a few cycles into a word: outputs clear at once, nothing emerges.
  task automatic test_reset_mid();
    int bad;
    send_word(8'hA5);
    @(posedge CLK); #1;
    @(posedge CLK); #3;
    RESET = 1'b1;
    #1;
    n_checks++; if (VALID_DOWN !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", VALID_DOWN); end
    n_checks++; if (READY_UP !== 1'b1) begin n_fail++; $display("FAIL mid_ready_up: got %b expected 1", READY_UP); end
    n_checks++; if (WORD_CNT !== 16'd0) begin n_fail++; $display("FAIL mid_cnt: got %0d expected 0", WORD_CNT); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b expected 0", BUSY); end
    n_checks++; if (DATA_DOWN !== '0) begin n_fail++; $display("FAIL mid_data: got %h expected 0", DATA_DOWN); end
    @(posedge CLK); #1 RESET = 1'b0;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      if (VALID_DOWN !== 1'b0 || BUSY !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL mid_no_output: %0d active cycles, expected 0", bad); end
    n_checks++; if (WORD_CNT !== 16'd0) begin n_fail++; $display("FAIL mid_cnt_after: got %0d expected 0", WORD_CNT); end
  endtask

  task automatic test_back_pressure();
    do_reset();
    src_q.push_back(8'h3C); exp_q.push_back({8'h3C, 5'h1D});
    src_q.push_back(8'hFF); exp_q.push_back({8'hFF, 5'h1B});
    run_stream(20, 300);
    n_checks++; if (WORD_CNT !== 16'd2) begin n_fail++; $display("FAIL bp_cnt: got %0d expected 2", WORD_CNT); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] vd[6];
    logic [4:0]       vc[6];
    vd = '{8'h00, 8'h01, 8'h80, 8'hA5, 8'h3C, 8'hFF};
    vc = '{5'h0F, 5'h0A, 5'h01, 5'h01, 5'h1D, 5'h1B};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      src_q.push_back(vd[i]);
      exp_q.push_back({vd[i], vc[i]});
    end
    run_stream(0, 400);
    n_checks++;
    if (hs_cyc.size() != 6) begin n_fail++; $display("FAIL b2b_count: got %0d outputs expected 6", hs_cyc.size()); end
    else begin
      for (int i = 1; i < 6; i++) begin
        n_checks++;
        if (hs_cyc[i] - hs_cyc[i-1] != GAP_EXP) begin
          n_fail++; $display("FAIL b2b_gap: got %0d cycles expected %0d", hs_cyc[i] - hs_cyc[i-1], GAP_EXP);
        end
      end
    end
    n_checks++; if (WORD_CNT !== 16'd6) begin n_fail++; $display("FAIL b2b_cnt: got %0d expected 6", WORD_CNT); end
  endtask

  // 4-bit counter: 15 -> 0 -> 1 across 17 words.
  task automatic test_wrap();
    logic [WIDTH-1:0] vd[3];
    logic [4:0]       vc[3];
    vd = '{8'h01, 8'h80, 8'h00};
    vc = '{5'h05, 5'h0E, 5'h00};
    do_reset();
    for (int i = 0; i < 15; i++) run_word2(vd[i % 3], vc[i % 3]);
    n_checks++; if (d2_word_cnt !== 4'd15) begin n_fail++; $display("FAIL wrap_15: got %0d expected 15", d2_word_cnt); end
    run_word2(vd[0], vc[0]);
    n_checks++; if (d2_word_cnt !== 4'd0) begin n_fail++; $display("FAIL wrap_16: got %0d expected 0", d2_word_cnt); end
    run_word2(vd[1], vc[1]);
    n_checks++; if (d2_word_cnt !== 4'd1) begin n_fail++; $display("FAIL wrap_17: got %0d expected 1", d2_word_cnt); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_known_vector();
    test_vectors();
    test_vectors_init0();
    test_reset_mid();
    test_back_pressure();
    test_back_to_back();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
